dbp_block_assembler: RTL
========================

// Module: dbp_block_assembler
// PURPOSE
// - Parametrised successor of the decoder DBP block buffer. Collects one base word plus
//   DATA_W+1 delta bit-planes from the upstream symbol decoder into a complete block.
// - Queues finished blocks in a DEPTH-entry FIFO towards the delta reconstruction stage.
// - Block boundaries come from an internal plane counter, not an upstream valid, so a
//   new block can start with no bubble cycle. A last_i protocol check flags framing errors.
// PARAMETERS
// - DATA_W      8  word width; block carries DATA_W+1 planes; legal 2..32
// - BLOCK_SIZE  8  words per block; plane width PW=BLOCK_SIZE-1; requires PW<=DATA_W
// - DEPTH       2  output FIFO entries, >=1, any value (not restricted to a power of 2)
// PORTS
// - clk_i   in   1              clock, rising edge
// - rst_i   in   1              asynchronous reset, active-high
// - clr_i   in   1              synchronous soft clear
// - data_i  in   DATA_W         base word, or plane in bits [DATA_W-1 -: PW]
// - push_i  in   1              upstream offers data_i; transfer = push_i & rdy_o
// - last_i  in   1              upstream marks the final plane of the block
// - rdy_o   out  1              word can be accepted this cycle
// - base_o  out  DATA_W         head block base
// - dbp_o   out  (DATA_W+1)*PW  head block planes; plane i at [i*PW +: PW], plane 0 pushed first
// - vld_o   out  1              FIFO non-empty
// - rdy_i   in   1              downstream accepts; pop = vld_o & rdy_i
// - fill_o  out  $clog2(DEPTH+1) FIFO occupancy
// - err_o   out  1              sticky framing error
// BEHAVIOUR
// - Reset (async, rst_i=1): state WAIT_BASE, cnt=0, FIFO empty, storage zero.
//   Outputs: vld_o=0, fill_o=0, err_o=0, base_o=0, dbp_o=0. rdy_o=1 once clr_i=0.
// - WAIT_BASE: rdy_o=1. On a transfer: base_q<=data_i, cnt<=0, go to FILLING.
// - FILLING: on a transfer, shift_q<=shift_q>>PW and load the new plane at index DATA_W.
//   The cnt-th transfer then lands at index cnt once DATA_W+1 planes are loaded.
//   cnt increments on each transfer.
// - Final plane (cnt==DATA_W): rdy_o=~full. Full means fill==DEPTH.
//   rdy_o does not depend on rdy_i (no combinational path from rdy_i to rdy_o).
// - On final-plane transfer: write {base_q, shifted planes incl. data_i} into the FIFO in
//   the same cycle, then go to WAIT_BASE. The block shows at vld_o on the next cycle.
// - Throughput: one word per cycle sustained. Block N+1 base may follow block N's last
//   plane directly.
// - last_i check: err_o<=1 if last_i=1 on a non-final plane transfer, or last_i=0 on a
//   final plane transfer. The block is still committed on the counter; last_i never
//   changes framing.
// - last_i on a base-word transfer is ignored.
// - FIFO: circular buffer, read data registered at the head (base_o/dbp_o = head entry).
//   Head is stable while vld_o=1 and rdy_i=0.
//   Pop and write in the same cycle: fill unchanged, pointers wrap modulo DEPTH.
//   When full, no write occurs even if a pop happens in the same cycle; the write
//   proceeds next cycle.
// - push_i while rdy_o=0: no effect, word is not consumed.
// - clr_i=1: highest priority. rdy_o=0 and any push is ignored.
//   Next cycle: FIFO empty, cnt=0, WAIT_BASE, err_o=0, base/shift registers zero.
//   A pop in the clr cycle is discarded.
// - rst_i mid-block: partial block and FIFO contents are lost, no output glitch beyond
//   forcing the reset values.
// STRUCTURE
// - ebpc_pkg: add function dbp_plane_w(bs)=bs-1 and an err-code localparam.
//   The default-size dbp_block_t already in ebpc_pkg remains for fixed-width users.
// - Sub-module dbp_block_fifo #(W, DEPTH): generic circular FIFO (wr/rd ptr, count, full/empty).
//   The assembler holds the FSM, plane counter, shift register, last_i checker and err flag.
// TESTING (DATA_W=8, BLOCK_SIZE=8, DEPTH=2 unless noted)
// - Single block: base 0xA5, then planes p0..p8=0x02,0x04,..,0x12 with last_i on p8 only.
//   Expect vld_o=1 one cycle after p8; base_o=0xA5; dbp_o[i*7+:7]=data[7:1] of p_i; err_o=0.
// - Back-to-back: 4 blocks, push_i=1 every cycle, rdy_i=1.
//   Expect 40 transfers in 40 cycles, 4 pops in order, fill_o<=1.
// - Backpressure: rdy_i=0, 3 blocks pushed. After 2 blocks fill_o=2, and rdy_o=0 at the
//   3rd block's p8. Raise rdy_i: p8 accepted one cycle after the first pop, order kept.
// - Framing error: last_i=1 on p3 -> err_o=1 next cycle. The block still commits after p8.
//   err_o stays 1 until clr_i.
// - Clear mid-block: clr_i after p4 with one block queued -> vld_o=0, fill_o=0, err_o=0.
//   The next base+9 planes form a clean block.
// - DEPTH=3, DATA_W=16, BLOCK_SIZE=4: 5 blocks with random rdy_i.
//   Scoreboard matches all blocks; pointers wrap correctly with a non-power-of-2 depth.

Source files
------------

// File: rtl/dbp_block_assembler_pkg.sv
// Shared types, constants and helpers for the DBP block assembler and its FIFO.
package dbp_block_assembler_pkg;

    typedef enum logic {
        WAIT_BASE = 1'b0,
        FILLING   = 1'b1
    } dbp_state_e;

    localparam logic DBP_ERR_FRAMING = 1'b1;

    localparam int DBP_DEF_DATA_W     = 8;
    localparam int DBP_DEF_BLOCK_SIZE = 8;

    function automatic int dbp_plane_w(input int bs);
        return bs - 1;
    endfunction

    // Fixed default-size block for users that do not parametrise.
    typedef struct packed {
        logic [DBP_DEF_DATA_W-1:0]                           base;
        logic [DBP_DEF_DATA_W:0][DBP_DEF_BLOCK_SIZE-2:0]     dbp;
    } dbp_block_t;

endpackage

// File: rtl/dbp_block_assembler_if.sv
// Upstream word bus and downstream block bus of the DBP block assembler.
interface dbp_block_assembler_if #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8
);
    localparam int PW = dbp_block_assembler_pkg::dbp_plane_w(BLOCK_SIZE);

    logic [DATA_W-1:0]        data_i;
    logic                     push_i;
    logic                     last_i;
    logic                     rdy_o;
    logic [DATA_W-1:0]        base_o;
    logic [(DATA_W+1)*PW-1:0] dbp_o;
    logic                     vld_o;
    logic                     rdy_i;

    modport slave (
        input  data_i, push_i, last_i, rdy_i,
        output rdy_o, base_o, dbp_o, vld_o
    );

    modport master (
        output data_i, push_i, last_i, rdy_i,
        input  rdy_o, base_o, dbp_o, vld_o
    );

endinterface

// File: rtl/dbp_block_assembler_fifo.sv
// Generic circular FIFO of complete blocks; head entry is presented directly from storage.
module dbp_block_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       wr_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       rd_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr;
    logic             do_rd;

    // Pointers wrap explicitly so any depth works, not only powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_wr     = wr_i & ~full_o;
    assign do_rd     = rd_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/dbp_block_assembler.sv
// Collects a base word plus DATA_W+1 bit-planes into a block and queues it for reconstruction.
module dbp_block_assembler
    import dbp_block_assembler_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int DEPTH      = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    dbp_block_assembler_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0] fill_o,
    output logic                       err_o
);
    localparam int PW      = dbp_plane_w(BLOCK_SIZE);
    localparam int NP      = DATA_W + 1;
    localparam int DBP_W   = NP * PW;
    localparam int CNT_W   = $clog2(NP);
    localparam int ENTRY_W = DATA_W + DBP_W;

    dbp_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] base_q;
    logic [DBP_W-1:0]  shift_q;
    logic              err_q;

    logic              final_plane;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rdy;
    logic              xfer;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [DBP_W-1:0]  shift_d;
    logic [ENTRY_W-1:0] fifo_head;

    // Framing is decided by the plane counter alone; last_i only feeds the error check.
    assign final_plane = (state_q == FILLING) && (cnt_q == CNT_W'(DATA_W));
    assign rdy         = ~clr_i & ~(final_plane & fifo_full);
    assign xfer        = bus.push_i & rdy;
    assign shift_d     = {bus.data_i[DATA_W-1 -: PW], shift_q[DBP_W-1:PW]};
    assign fifo_wr     = xfer & final_plane;
    assign fifo_rd     = bus.rdy_i & ~fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WAIT_BASE;
            cnt_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= WAIT_BASE;
            cnt_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
        end else if (xfer) begin
            unique case (state_q)
                WAIT_BASE: begin
                    base_q  <= bus.data_i;
                    cnt_q   <= '0;
                    state_q <= FILLING;
                end
                FILLING: begin
                    shift_q <= shift_d;
                    if (bus.last_i != final_plane) err_q <= DBP_ERR_FRAMING;
                    if (final_plane) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_BASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= WAIT_BASE;
            endcase
        end
    end

    dbp_block_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr_i),
        .wr_i      (fifo_wr),
        .wr_data_i ({base_q, shift_d}),
        .rd_i      (fifo_rd),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fill_o)
    );

    assign bus.rdy_o  = rdy;
    assign bus.vld_o  = ~fifo_empty;
    assign bus.base_o = fifo_head[ENTRY_W-1 -: DATA_W];
    assign bus.dbp_o  = fifo_head[DBP_W-1:0];
    assign err_o      = err_q;

endmodule
